pipeline_cpu: RTL and testbench
===============================

// Module: pipeline_cpu
// PURPOSE
//  Top of a 5-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset CPU with private instruction and data memories.
//  Self-contained: only clock and reset enter, and programs are preloaded into memory arrays by the bench.
//  Hazards are resolved in software: no forwarding and no interlock. Programs insert NOPs as required.
// PARAMETERS
//  IMEM_BYTES  128  instruction memory size in bytes
//  DMEM_BYTES  128  data memory size in bytes
// PORTS
//  clk  input  1  single clock; all state updates on rising edge
//  rst  input  1  asynchronous, active-low reset
// BEHAVIOUR
//  Reset (rst=0): PC=0, all pipeline registers = 0 (bubble = NOP), HI=LO=0.
//  Reset does not clear memories or the register file. Those contents are preloaded only.
//  Memories are byte arrays mem_array[0:N-1], little-endian.
//  - word at address a = {m[a+3],m[a+2],m[a+1],m[a]}.
//  - addresses are word-aligned; low 2 bits are ignored.
//  Instruction memory: combinational read. Data memory: combinational read, synchronous write.
//  Register file: file_array[0:31] x32 bits, 2 async read ports, 1 write port. $0 always reads 0.
//  Register file write-before-read: a WB write is visible to an ID read in the same cycle.
//  Supported instructions:
//  - R-type ALU: ADD(32), SUB(34), AND(36), OR(37), SLT(42, signed), SLL(0, rt<<shamt).
//  - MULTU(25): {HI,LO} = rs*rt, 64-bit unsigned, written at end of EX.
//  - MFHI(16), MFLO(18): read HI/LO in EX. MFHI/MFLO directly after MULTU sees the new value.
//  - I-type: LW(35), SW(43), ADDIU(9, sign-extended imm, no overflow trap).
//  - BEQ(4), J(2), JAL(3).
//  - Word 0x00000000 is a NOP (SLL $0,$0,0).
//  - Undefined opcode/funct: treated as NOP, with no register or memory write.
//  Arithmetic wraps modulo 2^32. No exceptions.
//  Control flow resolved in ID with one architectural delay slot; no flush.
//  - BEQ target = PC+4+(sext(imm)<<2).
//  - J/JAL target = {PC+4[31:28], addr26, 2'b00}.
//  - JAL writes PC+8 to $31.
//  PC wraps naturally. Fetch beyond IMEM_BYTES returns 0 (NOP).
//  Simultaneous WB write and ID read of the same register: ID receives the new value.
//  Observation signals, exact names at top level, required by benches:
//  - pc_try: PC being fetched in IF.
//  - first_instr: 32-bit word fetched in IF.
//  - opcode / funct: [31:26] / [5:0] of first_instr.
//  - rfile_wd: register-file write data in WB.
// STRUCTURE
//  Instance names are fixed for hierarchical preload:
//  - InstrMem (instr_memory), DatMem (data_memory), RegFile (reg_file).
//  - Each exposes its storage array as mem_array / mem_array / file_array.
//  Shared package holds opcode/funct constants, ALU-op encodings and the pipeline-register bundle types.
//  Control decoder (cpu_control) is the one natural extra sub-module. ALU and HI/LO stay inline.
// TESTING
//  Reset: rst=0 -> pc_try=0, first_instr=word at 0, HI=LO=0. Release -> pc_try steps 0,4,8,...
//  ALU: $1=5, $2=3. ADD $3,$1,$2 / SUB / AND / OR / SLT / SLL by 2, each followed by 3 NOPs.
//  - expected: 8 / 2 / 1 / 7 / 0 / 20, appearing on rfile_wd 4 cycles after fetch.
//  Memory: ADDIU $4,$0,-1 -> 0xFFFFFFFF. SW $4,8($0) -> DatMem bytes 8..11 = FF.
//  - LW $5,8($0) -> $5=0xFFFFFFFF. Also preloaded bytes 01 02 03 04 -> LW gives 0x04030201.
//  Multiply: $1=0xFFFFFFFF, $2=2. MULTU $1,$2 then MFHI $6, MFLO $7 -> $6=1, $7=0xFFFFFFFE.
//  Branch: BEQ $1,$1,+2 with delay-slot ADDIU $8,$0,1 -> $8=1; skipped instruction has no effect.
//  - BEQ on unequal registers falls through.
//  Jump: J 0x10 -> pc_try=0x10 two fetches later. JAL at PC=0x20 -> $31=0x28.
//  Async reset mid-program -> pipeline flushed, pc_try=0 immediately, register file retained.

Source files
------------

// File: rtl/pipeline_cpu_pkg.sv
// Shared constants and pipeline-register bundle types for the 5-stage MIPS-subset CPU.
package pipeline_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_HI, ALU_LO, ALU_LINK
    } alu_op_t;

    typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_sel_t;

    typedef struct packed {
        logic     reg_write;
        dst_sel_t dst_sel;
        logic     alu_imm;
        alu_op_t  alu_op;
        logic     mem_read;
        logic     mem_write;
        logic     multu;
        logic     branch;
        logic     jump;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [25:0] instr;
        logic [31:0] pc4;
    } if_id_t;

    typedef struct packed {
        logic        reg_write;
        logic        alu_imm;
        alu_op_t     alu_op;
        logic        mem_read;
        logic        mem_write;
        logic        multu;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc8;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  dest;
        logic [31:0] wd;
    } mem_wb_t;

endpackage

// File: rtl/cpu_control.sv
// Main decoder: opcode/funct to control word. Undefined encodings decode to an all-zero (no-effect) word.
module cpu_control
    import pipeline_cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    // Decode one instruction into its control word
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.dst_sel = DST_RD;
                case (funct)
                    FN_ADD:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
                    FN_SUB:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
                    FN_AND:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
                    FN_OR:    begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
                    FN_SLT:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
                    FN_SLL:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLL; end
                    FN_MFHI:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_HI;  end
                    FN_MFLO:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_LO;  end
                    FN_MULTU: ctrl.multu = 1'b1;
                    default:  ctrl.dst_sel = DST_RD;
                endcase
            end
            OP_ADDIU: begin
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RT;
                ctrl.alu_imm   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RT;
                ctrl.alu_imm   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.mem_read  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_imm   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: ctrl.branch = 1'b1;
            OP_J:   ctrl.jump = 1'b1;
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.dst_sel   = DST_RA;
                ctrl.alu_op    = ALU_LINK;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-array data memory, little-endian, combinational read and synchronous word write.
module data_memory #(
    parameter int BYTES = 128
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(BYTES)-1:2] word_addr,
    input  logic [31:0]              wd,
    output logic [31:0]              rd
);
    logic [7:0] mem_array [0:BYTES-1];

    assign rd = {mem_array[{word_addr, 2'd3}], mem_array[{word_addr, 2'd2}],
                 mem_array[{word_addr, 2'd1}], mem_array[{word_addr, 2'd0}]};

    // Store one word across four byte lanes
    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[{word_addr, 2'd0}] <= wd[7:0];
            mem_array[{word_addr, 2'd1}] <= wd[15:8];
            mem_array[{word_addr, 2'd2}] <= wd[23:16];
            mem_array[{word_addr, 2'd3}] <= wd[31:24];
        end
    end

endmodule

// File: rtl/instr_memory.sv
// Byte-array instruction memory, little-endian, combinational word read; out-of-range fetch returns 0 (NOP).
module instr_memory #(
    parameter int BYTES = 128
) (
    input  logic                     clk,
    input  logic                     load_en,
    input  logic [$clog2(BYTES)-1:0] load_addr,
    input  logic [7:0]               load_data,
    input  logic [31:0]              addr,
    output logic [31:0]              data
);
    localparam int AW = $clog2(BYTES);

    logic [7:0]    mem_array [0:BYTES-1];
    logic [AW-3:0] word;

    assign word = addr[AW-1:2];
    assign data = (addr < 32'(BYTES))
                ? {mem_array[{word, 2'd3}], mem_array[{word, 2'd2}],
                   mem_array[{word, 2'd1}], mem_array[{word, 2'd0}]}
                : '0;

    // Byte load port; normally tied off, contents arrive by preload
    always_ff @(posedge clk) begin
        if (load_en) mem_array[load_addr] <= load_data;
    end

endmodule

// File: rtl/reg_file.sv
// 32x32 register file, two async read ports with write-before-read bypass, $0 hardwired to zero.
module reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] file_array [0:31];

    assign rd1 = (ra1 == 5'd0) ? '0 : (we && wa == ra1) ? wd : file_array[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : (we && wa == ra2) ? wd : file_array[ra2];

    // Write port; writes to $0 are discarded
    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) file_array[wa] <= wd;
    end

endmodule

// File: rtl/pipeline_cpu.sv
// 5-stage MIPS-subset CPU top: no forwarding, no interlock, branches/jumps resolved in ID with one delay slot.
module pipeline_cpu
    import pipeline_cpu_pkg::*;
#(
    parameter int IMEM_BYTES = 128,
    parameter int DMEM_BYTES = 128
) (
    input logic clk,
    input logic rst
);
    localparam int IAW = $clog2(IMEM_BYTES);
    localparam int DAW = $clog2(DMEM_BYTES);

    logic [31:0] pc_try, pc_plus4, first_instr, rfile_wd;
    logic [5:0]  opcode, funct;
    logic [31:0] hi, lo;
    ctrl_t       if_ctrl;
    if_id_t      if_id;
    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;

    // ---------------- IF ----------------
    instr_memory #(.BYTES(IMEM_BYTES)) InstrMem (
        .clk       (clk),
        .load_en   (1'b0),
        .load_addr ({IAW{1'b0}}),
        .load_data (8'd0),
        .addr      (pc_try),
        .data      (first_instr)
    );

    assign opcode   = first_instr[31:26];
    assign funct    = first_instr[5:0];
    assign pc_plus4 = pc_try + 32'd4;

    // Decode happens in IF; the control word travels in IF/ID so only instr[25:0] is kept there
    cpu_control Control (
        .opcode (opcode),
        .funct  (funct),
        .ctrl   (if_ctrl)
    );

    // ---------------- ID ----------------
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] rd1, rd2, imm_sext, pc8, branch_target, jump_target, pc_next;

    assign rs = if_id.instr[25:21];
    assign rt = if_id.instr[20:16];
    assign rd = if_id.instr[15:11];

    reg_file RegFile (
        .clk (clk),
        .we  (mem_wb.reg_write),
        .wa  (mem_wb.dest),
        .wd  (mem_wb.wd),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    assign imm_sext      = {{16{if_id.instr[15]}}, if_id.instr[15:0]};
    assign pc8           = if_id.pc4 + 32'd4;
    assign branch_target = if_id.pc4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {if_id.pc4[31:28], if_id.instr, 2'b00};

    // Destination register and next fetch address chosen by the instruction in ID
    always_comb begin
        case (if_id.ctrl.dst_sel)
            DST_RT:  dest = rt;
            DST_RA:  dest = 5'd31;
            default: dest = rd;
        endcase
        pc_next = pc_plus4;
        if (if_id.ctrl.jump)
            pc_next = jump_target;
        else if (if_id.ctrl.branch && rd1 == rd2)
            pc_next = branch_target;
    end

    // ---------------- EX ----------------
    logic [31:0] op_b, alu_result;
    logic [63:0] product;

    assign op_b    = id_ex.alu_imm ? id_ex.imm : id_ex.b;
    assign product = {32'd0, id_ex.a} * {32'd0, id_ex.b};

    // ALU, including HI/LO moves and the JAL link value
    always_comb begin
        alu_result = '0;
        case (id_ex.alu_op)
            ALU_ADD:  alu_result = id_ex.a + op_b;
            ALU_SUB:  alu_result = id_ex.a - op_b;
            ALU_AND:  alu_result = id_ex.a & op_b;
            ALU_OR:   alu_result = id_ex.a | op_b;
            ALU_SLT:  alu_result = {31'd0, $signed(id_ex.a) < $signed(op_b)};
            ALU_SLL:  alu_result = op_b << id_ex.shamt;
            ALU_HI:   alu_result = hi;
            ALU_LO:   alu_result = lo;
            ALU_LINK: alu_result = id_ex.pc8;
            default:  alu_result = '0;
        endcase
    end

    // HI/LO written at the end of MULTU's EX cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            {hi, lo} <= '0;
        else if (id_ex.multu)
            {hi, lo} <= product;
    end

    // ---------------- MEM ----------------
    logic [31:0] load_data;

    data_memory #(.BYTES(DMEM_BYTES)) DatMem (
        .clk       (clk),
        .we        (ex_mem.mem_write),
        .word_addr (ex_mem.result[DAW-1:2]),
        .wd        (ex_mem.store_data),
        .rd        (load_data)
    );

    // ---------------- WB ----------------
    assign rfile_wd = mem_wb.wd;

    // PC and pipeline registers; reset turns every stage into a NOP bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_try <= '0;
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            pc_try           <= pc_next;

            if_id.ctrl       <= if_ctrl;
            if_id.instr      <= first_instr[25:0];
            if_id.pc4        <= pc_plus4;

            id_ex.reg_write  <= if_id.ctrl.reg_write;
            id_ex.alu_imm    <= if_id.ctrl.alu_imm;
            id_ex.alu_op     <= if_id.ctrl.alu_op;
            id_ex.mem_read   <= if_id.ctrl.mem_read;
            id_ex.mem_write  <= if_id.ctrl.mem_write;
            id_ex.multu      <= if_id.ctrl.multu;
            id_ex.shamt      <= if_id.instr[10:6];
            id_ex.dest       <= dest;
            id_ex.a          <= rd1;
            id_ex.b          <= rd2;
            id_ex.imm        <= imm_sext;
            id_ex.pc8        <= pc8;

            ex_mem.reg_write  <= id_ex.reg_write;
            ex_mem.mem_read   <= id_ex.mem_read;
            ex_mem.mem_write  <= id_ex.mem_write;
            ex_mem.dest       <= id_ex.dest;
            ex_mem.result     <= alu_result;
            ex_mem.store_data <= id_ex.b;

            mem_wb.reg_write <= ex_mem.reg_write;
            mem_wb.dest      <= ex_mem.dest;
            mem_wb.wd        <= ex_mem.mem_read ? load_data : ex_mem.result;
        end
    end

endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed bench for pipeline_cpu: programs preloaded hierarchically, results checked against hand-computed values.
module tb_pipeline_cpu;
    import pipeline_cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] exp_val;
    } vec_t;

    vec_t alu_vec [6];

    pipeline_cpu #(.IMEM_BYTES(128), .DMEM_BYTES(128)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp_v, cyc);
        end
    endtask

    task automatic clear_imem();
        for (int unsigned i = 0; i < 128; i++) dut.InstrMem.mem_array[i] <= 8'h00;
    endtask

    task automatic put_word(input int unsigned a, input logic [31:0] w);
        dut.InstrMem.mem_array[a]     <= w[7:0];
        dut.InstrMem.mem_array[a + 1] <= w[15:8];
        dut.InstrMem.mem_array[a + 2] <= w[23:16];
        dut.InstrMem.mem_array[a + 3] <= w[31:24];
    endtask

    task automatic set_reg(input int unsigned n, input logic [31:0] v);
        dut.RegFile.file_array[n] <= v;
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    // advance to the negedge following the target-th rising edge since release
    task automatic goto(input int unsigned target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #1 rst = 1'b0;

        // ---------- reset state + ALU table ----------
        alu_vec[0] = '{r_type(5'd1, 5'd2, 5'd3, 5'd0, FN_ADD), 32'd8};
        alu_vec[1] = '{r_type(5'd1, 5'd2, 5'd3, 5'd0, FN_SUB), 32'd2};
        alu_vec[2] = '{r_type(5'd1, 5'd2, 5'd3, 5'd0, FN_AND), 32'd1};
        alu_vec[3] = '{r_type(5'd1, 5'd2, 5'd3, 5'd0, FN_OR),  32'd7};
        alu_vec[4] = '{r_type(5'd1, 5'd2, 5'd3, 5'd0, FN_SLT), 32'd0};
        alu_vec[5] = '{r_type(5'd0, 5'd1, 5'd3, 5'd2, FN_SLL), 32'd20};

        hold_reset();
        clear_imem();
        for (int unsigned i = 0; i < 6; i++) put_word(16 * i, alu_vec[i].instr);
        set_reg(1, 32'd5);
        set_reg(2, 32'd3);
        @(negedge clk);
        check("reset_pc", dut.pc_try, 32'h0);
        check("reset_instr", dut.first_instr, 32'h00221820);
        check("reset_opcode", 32'(dut.opcode), 32'd0);
        check("reset_funct", 32'(dut.funct), 32'd32);
        check("reset_hi", dut.hi, 32'h0);
        check("reset_lo", dut.lo, 32'h0);
        check("reset_wd", dut.rfile_wd, 32'h0);
        rst = 1'b1;
        cyc = 0;
        goto(1);
        check("pc_step1", dut.pc_try, 32'h4);
        goto(2);
        check("pc_step2", dut.pc_try, 32'h8);
        for (int unsigned i = 0; i < 6; i++) begin
            goto(4 * i + 4);
            check($sformatf("alu[%0d]", i), dut.rfile_wd, alu_vec[i].exp_val);
        end

        // ---------- memory: ADDIU / SW / LW ----------
        hold_reset();
        clear_imem();
        put_word(0,  i_type(OP_ADDIU, 5'd0, 5'd4, 16'hFFFF));
        put_word(16, i_type(OP_SW, 5'd0, 5'd4, 16'd8));
        put_word(20, i_type(OP_LW, 5'd0, 5'd5, 16'd8));
        put_word(24, i_type(OP_LW, 5'd0, 5'd6, 16'd12));
        for (int unsigned i = 8; i < 12; i++) dut.DatMem.mem_array[i] <= 8'h00;
        dut.DatMem.mem_array[12] <= 8'h01;
        dut.DatMem.mem_array[13] <= 8'h02;
        dut.DatMem.mem_array[14] <= 8'h03;
        dut.DatMem.mem_array[15] <= 8'h04;
        set_reg(5, 32'd0);
        set_reg(6, 32'd0);
        release_reset();
        goto(4);
        check("addiu_wd", dut.rfile_wd, 32'hFFFFFFFF);
        goto(9);
        check("lw_ff_wd", dut.rfile_wd, 32'hFFFFFFFF);
        goto(10);
        check("lw_le_wd", dut.rfile_wd, 32'h04030201);
        goto(12);
        check("sw_bytes", {dut.DatMem.mem_array[11], dut.DatMem.mem_array[10],
                           dut.DatMem.mem_array[9], dut.DatMem.mem_array[8]}, 32'hFFFFFFFF);
        check("reg5", dut.RegFile.file_array[5], 32'hFFFFFFFF);
        check("reg6", dut.RegFile.file_array[6], 32'h04030201);

        // ---------- branch taken / not taken, undefined encodings ----------
        hold_reset();
        clear_imem();
        put_word(0,  i_type(OP_BEQ, 5'd1, 5'd1, 16'd2));
        put_word(4,  i_type(OP_ADDIU, 5'd0, 5'd8, 16'd1));
        put_word(8,  i_type(OP_ADDIU, 5'd0, 5'd9, 16'd1));
        put_word(12, i_type(OP_BEQ, 5'd1, 5'd2, 16'd2));
        put_word(16, i_type(OP_ADDIU, 5'd0, 5'd10, 16'd1));
        put_word(20, i_type(OP_ADDIU, 5'd0, 5'd11, 16'd1));
        put_word(24, r_type(5'd1, 5'd2, 5'd13, 5'd0, 6'd63));
        put_word(28, i_type(6'h3F, 5'd1, 5'd13, 16'h1234));
        set_reg(1, 32'd5);
        set_reg(2, 32'd3);
        set_reg(8, 32'd0);
        set_reg(9, 32'h55);
        set_reg(10, 32'd0);
        set_reg(11, 32'd0);
        set_reg(13, 32'h99);
        release_reset();
        goto(2);
        check("beq_target_pc", dut.pc_try, 32'd12);
        goto(4);
        check("beq_fallthru_pc", dut.pc_try, 32'd20);
        goto(14);
        check("delay_slot_r8", dut.RegFile.file_array[8], 32'd1);
        check("skipped_r9", dut.RegFile.file_array[9], 32'h55);
        check("nt_delay_r10", dut.RegFile.file_array[10], 32'd1);
        check("nt_fallthru_r11", dut.RegFile.file_array[11], 32'd1);
        check("undef_r13", dut.RegFile.file_array[13], 32'h99);

        // ---------- J / JAL ----------
        hold_reset();
        clear_imem();
        put_word(0,  j_type(OP_J, 26'h4));
        put_word(8,  i_type(OP_ADDIU, 5'd0, 5'd12, 16'd1));
        put_word(32, j_type(OP_JAL, 26'hC));
        set_reg(12, 32'h77);
        set_reg(31, 32'd0);
        release_reset();
        goto(2);
        check("j_pc", dut.pc_try, 32'h10);
        goto(8);
        check("jal_pc", dut.pc_try, 32'h30);
        goto(10);
        check("jal_wd", dut.rfile_wd, 32'h28);
        goto(12);
        check("jal_r31", dut.RegFile.file_array[31], 32'h28);
        check("j_skipped_r12", dut.RegFile.file_array[12], 32'h77);

        // ---------- MULTU / MFHI / MFLO, then async reset mid-program ----------
        hold_reset();
        clear_imem();
        put_word(0, r_type(5'd1, 5'd2, 5'd0, 5'd0, FN_MULTU));
        put_word(4, r_type(5'd0, 5'd0, 5'd6, 5'd0, FN_MFHI));
        put_word(8, r_type(5'd0, 5'd0, 5'd7, 5'd0, FN_MFLO));
        set_reg(1, 32'hFFFFFFFF);
        set_reg(2, 32'd2);
        set_reg(6, 32'd0);
        set_reg(7, 32'd0);
        release_reset();
        goto(5);
        check("mfhi_wd", dut.rfile_wd, 32'd1);
        goto(6);
        check("mflo_wd", dut.rfile_wd, 32'hFFFFFFFE);
        goto(10);
        check("hi", dut.hi, 32'd1);
        check("lo", dut.lo, 32'hFFFFFFFE);
        check("reg6_hi", dut.RegFile.file_array[6], 32'd1);
        check("reg7_lo", dut.RegFile.file_array[7], 32'hFFFFFFFE);
        #2 rst = 1'b0;
        #1;
        check("async_rst_pc", dut.pc_try, 32'h0);
        check("async_rst_wd", dut.rfile_wd, 32'h0);
        check("async_rst_hi", dut.hi, 32'h0);
        check("async_rst_lo", dut.lo, 32'h0);
        check("rf_kept_r6", dut.RegFile.file_array[6], 32'd1);
        check("rf_kept_r7", dut.RegFile.file_array[7], 32'hFFFFFFFE);
        @(negedge clk);
        @(negedge clk);
        check("held_rst_pc", dut.pc_try, 32'h0);
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
